// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU-priority single grant per cycle with a starvation
// override for the debug master, plus a read-tag pipeline that steers returned words.
module dmem_port_arbiter #(
  parameter int READ_LAT     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [14:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [15:0] dbg_rdata,
  output logic [14:0] mem_raddr,
  input  logic [15:0] mem_rdata,
  output logic        mem_wen,
  output logic [14:0] mem_waddr,
  output logic [15:0] mem_wdata,
  output logic [7:0]  starve_cnt
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  // With the override disabled the counter still runs, saturating at its full range.
  localparam logic [7:0] SAT   = (STARVE_LIMIT == 0) ? 8'hFF : 8'(STARVE_LIMIT);

  logic [7:0]          r_starve_cnt;
  logic [READ_LAT-1:0] r_tag_valid;
  logic [READ_LAT-1:0] r_tag_owner;
  logic [READ_LAT-1:0] w_tag_valid_next;
  logic [READ_LAT-1:0] w_tag_owner_next;

  logic        w_force;
  logic        w_cpu_gnt;
  logic        w_dbg_gnt;
  logic        w_any_gnt;
  logic        w_we;
  logic        w_load;
  logic [14:0] w_addr;

  assign w_force   = (STARVE_LIMIT != 0) && (r_starve_cnt == LIMIT) && dbg_req;
  assign w_cpu_gnt = rst_n && cpu_req && !w_force;
  assign w_dbg_gnt = rst_n && dbg_req && (w_force || !cpu_req);
  assign w_any_gnt = w_cpu_gnt || w_dbg_gnt;

  assign w_we   = w_dbg_gnt ? dbg_we   : cpu_we;
  assign w_addr = w_dbg_gnt ? dbg_addr : cpu_addr;
  assign w_load = w_any_gnt && !w_we;

  assign cpu_gnt   = w_cpu_gnt;
  assign dbg_gnt   = w_dbg_gnt;
  assign mem_wen   = w_any_gnt && w_we;
  assign mem_waddr = mem_wen ? w_addr : 15'd0;
  assign mem_raddr = w_load  ? w_addr : 15'd0;
  assign mem_wdata = w_dbg_gnt ? dbg_wdata : cpu_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 8'd0;
    end else if (!dbg_req || w_dbg_gnt) begin
      r_starve_cnt <= 8'd0;
    end else if (r_starve_cnt != SAT) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  assign starve_cnt = r_starve_cnt;

  // Owner bit: 0 = CPU, 1 = debug. Stage 0 captures this cycle's granted load.
  assign w_tag_valid_next[0] = w_load;
  assign w_tag_owner_next[0] = w_dbg_gnt;

  genvar gi;
  generate
    for (gi = 1; gi < READ_LAT; gi++) begin : g_tag_shift
      assign w_tag_valid_next[gi] = r_tag_valid[gi-1];
      assign w_tag_owner_next[gi] = r_tag_owner[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_valid <= '0;
      r_tag_owner <= '0;
    end else begin
      r_tag_valid <= w_tag_valid_next;
      r_tag_owner <= w_tag_owner_next;
    end
  end

  assign cpu_rvalid = r_tag_valid[READ_LAT-1] && !r_tag_owner[READ_LAT-1];
  assign dbg_rvalid = r_tag_valid[READ_LAT-1] &&  r_tag_owner[READ_LAT-1];
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter with a 2-cycle-latency memory model.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [14:0] cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic [14:0] mem_raddr, mem_waddr;
  logic [15:0] mem_rdata, mem_wdata;
  logic        mem_wen;
  logic [7:0]  starve_cnt;

  int total;
  int bad;

  logic [15:0] mem [0:32767];
  logic [15:0] r_p1;

  dmem_port_arbiter #(.READ_LAT(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .starve_cnt(starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: raddr in cycle N gives rdata in cycle N+2; writes land at the edge.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
    r_p1      <= mem[mem_raddr];
    mem_rdata <= r_p1;
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0; dbg_we = 1'b0;
    cpu_addr = 15'd0; dbg_addr = 15'd0;
    @(negedge clk);
    total++; if (cpu_gnt !== 1'b0) begin bad++; $display("FAIL reset_cpu_gnt got=%b want=0", cpu_gnt); end
    total++; if (dbg_gnt !== 1'b0) begin bad++; $display("FAIL reset_dbg_gnt got=%b want=0", dbg_gnt); end
    total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL reset_mem_wen got=%b want=0", mem_wen); end
    total++; if (starve_cnt !== 8'd0) begin bad++; $display("FAIL reset_starve got=%0d want=0", starve_cnt); end
    total++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b want=00", {cpu_rvalid, dbg_rvalid}); end
    next_cycle;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL release_cpu_gnt got=%b want=1", cpu_gnt); end
    total++; if (dbg_gnt !== 1'b0) begin bad++; $display("FAIL release_dbg_gnt got=%b want=0", dbg_gnt); end
    next_cycle;
    cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (3) next_cycle;
    $display("test_reset done");
  endtask

  task automatic test_cpu_load;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0008;
    @(negedge clk);
    total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL load_cpu_gnt got=%b want=1", cpu_gnt); end
    total++; if (dbg_gnt !== 1'b0) begin bad++; $display("FAIL load_dbg_gnt got=%b want=0", dbg_gnt); end
    total++; if (mem_raddr !== 15'h0008) begin bad++; $display("FAIL load_raddr got=%h want=0008", mem_raddr); end
    total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL load_wen got=%b want=0", mem_wen); end
    next_cycle;
    cpu_req = 1'b0;
    @(negedge clk);
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL load_early_rvalid got=%b want=0", cpu_rvalid); end
    next_cycle;
    @(negedge clk);
    total++; if (cpu_rvalid !== 1'b1) begin bad++; $display("FAIL load_cpu_rvalid got=%b want=1", cpu_rvalid); end
    total++; if (cpu_rdata !== 16'hBEEF) begin bad++; $display("FAIL load_cpu_rdata got=%h want=beef", cpu_rdata); end
    total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL load_dbg_rvalid got=%b want=0", dbg_rvalid); end
    next_cycle;
    @(negedge clk);
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL load_rvalid_once got=%b want=0", cpu_rvalid); end
    next_cycle;
    $display("test_cpu_load done");
  endtask

  task automatic test_dbg_store;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 15'h0040; dbg_wdata = 16'h1234;
    @(negedge clk);
    total++; if (dbg_gnt !== 1'b1) begin bad++; $display("FAIL store_dbg_gnt got=%b want=1", dbg_gnt); end
    total++; if (cpu_gnt !== 1'b0) begin bad++; $display("FAIL store_cpu_gnt got=%b want=0", cpu_gnt); end
    total++; if (mem_wen !== 1'b1) begin bad++; $display("FAIL store_wen got=%b want=1", mem_wen); end
    total++; if (mem_waddr !== 15'h0040) begin bad++; $display("FAIL store_waddr got=%h want=0040", mem_waddr); end
    total++; if (mem_wdata !== 16'h1234) begin bad++; $display("FAIL store_wdata got=%h want=1234", mem_wdata); end
    next_cycle;
    dbg_we = 1'b0;
    @(negedge clk);
    total++; if (dbg_gnt !== 1'b1) begin bad++; $display("FAIL dload_gnt got=%b want=1", dbg_gnt); end
    total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL dload_wen got=%b want=0", mem_wen); end
    total++; if (mem_raddr !== 15'h0040) begin bad++; $display("FAIL dload_raddr got=%h want=0040", mem_raddr); end
    next_cycle;
    dbg_req = 1'b0;
    @(negedge clk);
    total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL dload_early_rvalid got=%b want=0", dbg_rvalid); end
    next_cycle;
    @(negedge clk);
    total++; if (dbg_rvalid !== 1'b1) begin bad++; $display("FAIL dload_rvalid got=%b want=1", dbg_rvalid); end
    total++; if (dbg_rdata !== 16'h1234) begin bad++; $display("FAIL dload_rdata got=%h want=1234", dbg_rdata); end
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL dload_cpu_rvalid got=%b want=0", cpu_rvalid); end
    next_cycle;
    $display("test_dbg_store done");
  endtask

  task automatic test_starvation;
    logic       exp_cg, exp_dg, exp_cr, exp_dr;
    logic [7:0] exp_cnt;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0030;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 15'h0020;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) dbg_req = 1'b0;
      if (c == 6) cpu_req = 1'b0;
      exp_dg  = (c == 4);
      exp_cg  = (c < 6) && (c != 4);
      exp_cnt = (c <= 4) ? 8'(c) : 8'd0;
      exp_cr  = (c >= 2) && (c != 6);
      exp_dr  = (c == 6);
      @(negedge clk);
      total++; if (cpu_gnt !== exp_cg) begin bad++; $display("FAIL starve_cpu_gnt c=%0d got=%b want=%b", c, cpu_gnt, exp_cg); end
      total++; if (dbg_gnt !== exp_dg) begin bad++; $display("FAIL starve_dbg_gnt c=%0d got=%b want=%b", c, dbg_gnt, exp_dg); end
      total++; if (starve_cnt !== exp_cnt) begin bad++; $display("FAIL starve_cnt c=%0d got=%0d want=%0d", c, starve_cnt, exp_cnt); end
      total++; if (cpu_rvalid !== exp_cr) begin bad++; $display("FAIL starve_cpu_rvalid c=%0d got=%b want=%b", c, cpu_rvalid, exp_cr); end
      total++; if (dbg_rvalid !== exp_dr) begin bad++; $display("FAIL starve_dbg_rvalid c=%0d got=%b want=%b", c, dbg_rvalid, exp_dr); end
      if (exp_dr) begin
        total++; if (dbg_rdata !== 16'hD00D) begin bad++; $display("FAIL starve_dbg_rdata got=%h want=d00d", dbg_rdata); end
      end
      if (exp_cr) begin
        total++; if (cpu_rdata !== 16'hC0C0) begin bad++; $display("FAIL starve_cpu_rdata c=%0d got=%h want=c0c0", c, cpu_rdata); end
      end
      next_cycle;
    end
    $display("test_starvation done");
  endtask

  task automatic test_interleave;
    logic        exp_cr, exp_dr;
    logic [15:0] exp_data;
    int          g;
    cpu_we = 1'b0; dbg_we = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c < 6 && (c % 2) == 0) begin
        cpu_req = 1'b1; dbg_req = 1'b0; cpu_addr = 15'h0100 + 15'(c);
      end else if (c < 6) begin
        cpu_req = 1'b0; dbg_req = 1'b1; dbg_addr = 15'h0200 + 15'(c);
      end else begin
        cpu_req = 1'b0; dbg_req = 1'b0;
      end
      @(negedge clk);
      total++; if (cpu_gnt !== (c < 6 && (c % 2) == 0)) begin bad++; $display("FAIL inter_cpu_gnt c=%0d got=%b", c, cpu_gnt); end
      total++; if (dbg_gnt !== (c < 6 && (c % 2) == 1)) begin bad++; $display("FAIL inter_dbg_gnt c=%0d got=%b", c, dbg_gnt); end
      if (c >= 2) begin
        g = c - 2;
        exp_cr   = ((g % 2) == 0);
        exp_dr   = ((g % 2) == 1);
        exp_data = exp_cr ? (16'hA000 + 16'(g)) : (16'hB000 + 16'(g));
        total++; if (cpu_rvalid !== exp_cr) begin bad++; $display("FAIL inter_cpu_rvalid c=%0d got=%b want=%b", c, cpu_rvalid, exp_cr); end
        total++; if (dbg_rvalid !== exp_dr) begin bad++; $display("FAIL inter_dbg_rvalid c=%0d got=%b want=%b", c, dbg_rvalid, exp_dr); end
        total++; if (mem_rdata !== exp_data || (exp_cr ? cpu_rdata : dbg_rdata) !== exp_data) begin
          bad++; $display("FAIL inter_rdata c=%0d cpu=%h dbg=%h want=%h", c, cpu_rdata, dbg_rdata, exp_data);
        end
      end
      next_cycle;
    end
    $display("test_interleave done");
  endtask

  task automatic test_reset_midflight;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0008;
    @(negedge clk);
    total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL mid_cpu_gnt got=%b want=1", cpu_gnt); end
    next_cycle;
    cpu_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 15'h0040;
    @(negedge clk);
    total++; if (dbg_gnt !== 1'b1) begin bad++; $display("FAIL mid_dbg_gnt got=%b want=1", dbg_gnt); end
    next_cycle;
    dbg_req = 1'b0; rst_n = 1'b0;
    for (int c = 2; c < 5; c++) begin
      if (c == 3) rst_n = 1'b1;
      @(negedge clk);
      total++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin bad++; $display("FAIL mid_dropped c=%0d got=%b want=00", c, {cpu_rvalid, dbg_rvalid}); end
      next_cycle;
    end
    cpu_req = 1'b1; cpu_addr = 15'h0008;
    @(negedge clk);
    total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL mid_new_gnt got=%b want=1", cpu_gnt); end
    next_cycle;
    cpu_req = 1'b0;
    next_cycle;
    @(negedge clk);
    total++; if (cpu_rvalid !== 1'b1) begin bad++; $display("FAIL mid_new_rvalid got=%b want=1", cpu_rvalid); end
    total++; if (cpu_rdata !== 16'hBEEF) begin bad++; $display("FAIL mid_new_rdata got=%h want=beef", cpu_rdata); end
    next_cycle;
    $display("test_reset_midflight done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 15'd0; cpu_wdata = 16'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 15'd0; dbg_wdata = 16'd0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'd0;
    mem[15'h0008] = 16'hBEEF;
    mem[15'h0020] = 16'hD00D;
    mem[15'h0030] = 16'hC0C0;
    for (int i = 0; i < 6; i++) begin
      mem[15'h0100 + 15'(i)] = 16'hA000 + 16'(i);
      mem[15'h0200 + 15'(i)] = 16'hB000 + 16'(i);
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_cpu_load;
    test_dbg_store;
    test_starvation;
    test_interleave;
    test_reset_midflight;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the data-memory port (read port 1 plus the write port of `mem`) between two requesters: the CPU load/store stage (primary) and a debug/loader master (secondary). It grants one access per cycle with CPU priority and a starvation override for the secondary. It tracks in-flight reads through a tag pipeline matched to the memory read latency, and routes each returned word to its owner. It sits between the pipeline's write-back/load logic and `mem`.

## Interface
- `READ_LAT`, 2: memory read latency in cycles from `mem_raddr` to valid `mem_rdata`; legal range 1..4.
- `STARVE_LIMIT`, 4: consecutive denied cycles after which a pending debug request wins over the CPU; 0 disables the override; legal range 0..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; held until granted.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  15  word address [15:1].
- `cpu_wdata`  in  16  store data.
- `cpu_gnt`  out  1  access accepted this cycle (combinational).
- `cpu_rvalid`  out  1  read data for CPU valid this cycle.
- `cpu_rdata`  out  16  read data.
- `dbg_req`, `dbg_we`, `dbg_addr[15:1]`, `dbg_wdata[15:0]`  in  same meaning for the debug master.
- `dbg_gnt`, `dbg_rvalid`, `dbg_rdata[15:0]`  out  same meaning for the debug master.
- `mem_raddr`  out  15  to `mem` read port 1.
- `mem_rdata`  in  16  from `mem` read port 1.
- `mem_wen`  out  1  write enable.
- `mem_waddr`  out  15  write address.
- `mem_wdata`  out  16  write data.
- `starve_cnt`  out  8  current debug starvation count (observability).

## Operation
- Arbitration, evaluated combinationally each cycle:
  - Force = `STARVE_LIMIT != 0 && starve_cnt == STARVE_LIMIT && dbg_req`.
  - If Force: `dbg_gnt = 1`, `cpu_gnt = 0`.
  - Else if `cpu_req`: `cpu_gnt = 1`.
  - Else if `dbg_req`: `dbg_gnt = 1`.
  - At most one grant per cycle. Both grants are 0 while `rst_n` is low.
- Granted access, same cycle:
  - Store: `mem_wen = 1`; `mem_waddr` and `mem_wdata` taken from the winner.
  - Load: `mem_raddr` set to the winner's address; `mem_wen = 0`.
  - No grant: `mem_wen = 0`; `mem_raddr` and `mem_waddr` = 0.
- Tag pipeline:
  - `READ_LAT` stages of {valid, owner}; stage 0 is loaded with {granted load, owner} each cycle and shifts every cycle.
  - When the last stage is valid, the matching `*_rvalid` is 1 for exactly one cycle. Both `cpu_rdata` and `dbg_rdata` always carry `mem_rdata`, but only the owner's `rvalid` is asserted.
- Starvation counter:
  - On each clock edge: 0 if `!dbg_req` or `dbg_gnt`; else `starve_cnt + 1`, saturating at `STARVE_LIMIT` (at 255 when `STARVE_LIMIT = 0`).
- The arbiter does no data hazard checking. A store and a later load to the same address are ordered only by grant order.

## Timing
- Reset (async, `rst_n` low): tag pipeline cleared, `starve_cnt = 0`, all `*_rvalid = 0`, `mem_wen = 0`, both grants 0.
- Reset mid-operation: any in-flight reads are dropped; no `rvalid` is produced for them after release.
- Grant latency: 0 cycles; a request in cycle N is granted in cycle N if it wins.
- Read response:
  - A load granted in cycle N returns `rvalid` in cycle N+`READ_LAT`.
  - Throughput is one access per cycle; back-to-back loads give back-to-back `rvalid`s in grant order.
- Store completes at the clock edge ending its grant cycle.
- Simultaneous requests: CPU wins unless Force. With `STARVE_LIMIT = 4`, a debug request held against continuous CPU requests is granted in its 5th cycle (counts 0,1,2,3 denied, count 4 forces).
- Denied requester keeps its request and payload stable; changing them before grant is undefined.

## Test plan
- Reset: assert `rst_n = 0` with both requesting → grants 0, `mem_wen = 0`, `starve_cnt = 0`; release → `cpu_gnt = 1` the same cycle.
- CPU load from 0x0010 (addr[15:1] = 0x0008), memory holds 0xBEEF, `READ_LAT = 2` → `cpu_gnt` in cycle N, `cpu_rvalid = 1` with `cpu_rdata = 0xBEEF` in cycle N+2, `dbg_rvalid = 0`.
- Debug store 0x1234 to word 0x0040 with CPU idle → `dbg_gnt = 1`, `mem_wen = 1`, `mem_waddr = 0x0040`, `mem_wdata = 0x1234`; a following debug load returns 0x1234.
- Starvation: CPU requests every cycle, debug load held from cycle 0 → `dbg_gnt` in cycle 4 only, `cpu_gnt = 0` that cycle, `starve_cnt` 0→4 then 0.
- Interleaved loads: alternating CPU/debug grants over 6 cycles → each `rvalid` lands on its correct owner `READ_LAT` cycles later, in order, with no loss.
- Reset pulse while 2 reads are in flight → no `rvalid` after release; new loads complete normally.
